training_sample_fetcher: RTL and testbench

TRAINING_SAMPLE_FETCHER -- requirements
Module: training_sample_fetcher

---
 rtl/knn_pkg.sv | 22 ++
 rtl/sample_addr_gen.sv | 47 ++++
 rtl/training_sample_fetcher.sv | 128 ++++++++++++
 tb/tb_training_sample_fetcher.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/knn_pkg.sv
// Shared definitions for the k-NN training sample fetcher: fetch-state encoding
// and the per-sample memory layout (words per sample).
package knn_pkg;

  localparam logic [1:0] FS_IDLE  = 2'd0;
  localparam logic [1:0] FS_FETCH = 2'd1;
  localparam logic [1:0] FS_DRAIN = 2'd2;
  localparam logic [1:0] FS_DONE  = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = FS_IDLE,
    FETCH = FS_FETCH,
    DRAIN = FS_DRAIN,
    DONE  = FS_DONE
  } fetch_state_t;

  // Words per sample: M*N pixel words followed by one label word.
  function automatic int knn_wps(input int m, input int n);
    return m * n + 1;
  endfunction

endpackage

// File: rtl/sample_addr_gen.sv
// Sample index and word counter for the fetcher; produces the memory word
// address base + word, with base = sample_idx * words-per-sample.
module sample_addr_gen
  import knn_pkg::*;
#(
  parameter int M            = 2,
  parameter int N            = 2,
  parameter int MAX_ELEMENTS = 3,
  parameter int ADDR_W       = 8,
  parameter bit WRAP         = 1'b0,
  parameter int CNT_W        = $clog2(knn_wps(M, N) + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              word_inc,
  input  logic              sample_inc,
  output logic [CNT_W-1:0]  word_cnt,
  output logic [ADDR_W-1:0] addr,
  output logic              reach_max
);

  localparam int WPS   = knn_wps(M, N);
  localparam int IDX_W = $clog2(MAX_ELEMENTS + 1);

  logic [IDX_W-1:0]  sample_idx;
  logic [ADDR_W-1:0] base;

  // High when the next increment brings the index to MAX_ELEMENTS.
  assign reach_max = (sample_idx == IDX_W'(MAX_ELEMENTS - 1));
  assign base      = ADDR_W'(sample_idx) * ADDR_W'(WPS);
  assign addr      = base + ADDR_W'(word_cnt);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      sample_idx <= '0;
      word_cnt   <= '0;
    end else if (sample_inc) begin
      word_cnt <= '0;
      if (reach_max && WRAP) sample_idx <= '0;
      else                   sample_idx <= sample_idx + 1'b1;
    end else if (word_inc) begin
      word_cnt <= word_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/training_sample_fetcher.sv
// Fetches one M x N training sample plus its label from a 1-cycle-latency memory
// per request. Define SAMPLE_WRAP_EN to wrap the sample index instead of latching all_read.
module training_sample_fetcher
  import knn_pkg::*;
#(
  parameter int M            = 2,
  parameter int N            = 2,
  parameter int W            = 8,
  parameter int TYPE_W       = 2,
  parameter int MAX_ELEMENTS = 3,
  parameter int ADDR_W       = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                data_request,
  output logic                mem_rd_en,
  output logic [ADDR_W-1:0]   mem_addr,
  input  logic [W-1:0]        mem_rdata,
  output logic [W*M*N-1:0]    training_data,
  output logic [TYPE_W-1:0]   training_data_type,
  output logic                read_done,
  output logic                all_read,
  output logic                busy
);

  localparam int WPS   = knn_wps(M, N);
  localparam int PIX   = M * N;
  localparam int CNT_W = $clog2(WPS + 1);
  localparam logic [CNT_W-1:0] WPS_C  = CNT_W'(WPS);
  localparam logic [CNT_W-1:0] LAST_C = CNT_W'(WPS - 1);
`ifdef SAMPLE_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  if (longint'(MAX_ELEMENTS) * longint'(WPS) > (longint'(1) << ADDR_W)) begin : g_addr_range_check
    $error("training_sample_fetcher: MAX_ELEMENTS*WPS exceeds the ADDR_W address space");
  end

  fetch_state_t      state, state_nxt;
  logic              issue, sample_done, last_capture, reach_max;
  logic              cap_v;
  logic [CNT_W-1:0]  word_cnt, issue_idx, cap_idx;
  logic [ADDR_W-1:0] addr_nxt;

  sample_addr_gen #(
    .M(M), .N(N), .MAX_ELEMENTS(MAX_ELEMENTS), .ADDR_W(ADDR_W), .WRAP(WRAP), .CNT_W(CNT_W)
  ) u_addr_gen (
    .clk(clk), .rst(rst), .clear(start), .word_inc(issue), .sample_inc(sample_done),
    .word_cnt(word_cnt), .addr(addr_nxt), .reach_max(reach_max)
  );

  // Request handshake: data_request is a level sampled only in IDLE while
  // all_read is low (or wrapping); it is never queued. read_done is a one-cycle
  // pulse marking training_data/training_data_type valid. start always wins.
  assign last_capture = cap_v && (cap_idx == LAST_C);
  assign busy         = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    issue       = 1'b0;
    sample_done = 1'b0;
    case (state)
      IDLE: begin
        if (data_request && (WRAP || !all_read)) begin
          issue     = 1'b1;
          state_nxt = FETCH;
        end
      end
      FETCH: begin
        if (word_cnt < WPS_C) issue = 1'b1;
        else                  state_nxt = DRAIN;
      end
      DRAIN: if (last_capture) state_nxt = DONE;
      DONE: begin
        sample_done = 1'b1;
        state_nxt   = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (start) begin
      state_nxt   = IDLE;
      issue       = 1'b0;
      sample_done = 1'b0;
    end
  end

  // Word j issued at edge t is sampled by memory at t+1 and captured here at t+2.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_rd_en          <= 1'b0;
      mem_addr           <= '0;
      issue_idx          <= '0;
      cap_v              <= 1'b0;
      cap_idx            <= '0;
      training_data      <= '0;
      training_data_type <= '0;
      read_done          <= 1'b0;
      all_read           <= 1'b0;
    end else begin
      mem_rd_en <= issue;
      if (issue) begin
        mem_addr  <= addr_nxt;
        issue_idx <= word_cnt;
      end
      cap_v     <= mem_rd_en && !start;
      cap_idx   <= issue_idx;
      read_done <= last_capture && !start;
      if (cap_v && !start) begin
        for (int k = 0; k < PIX; k++) begin
          if (cap_idx == CNT_W'(k)) training_data[k*W +: W] <= mem_rdata;
        end
        if (cap_idx == LAST_C) training_data_type <= mem_rdata[TYPE_W-1:0];
      end
      if (start)                         all_read <= 1'b0;
      else if (sample_done && reach_max) all_read <= 1'b1;
      else if (WRAP)                     all_read <= 1'b0;
    end
  end

endmodule

// File: tb/tb_training_sample_fetcher.sv
// Self-checking bench for training_sample_fetcher: timeline model of the fetch
// protocol plus hand-computed address and sample literals.
module tb_training_sample_fetcher;

  localparam int M = 2, N = 2, W = 8, TYPE_W = 2, MAX_ELEMENTS = 3, ADDR_W = 8;
  localparam int PIX = M * N;
  localparam int WPS = PIX + 1;
  localparam int DW  = W * PIX;
`ifdef SAMPLE_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  // clock / reset / DUT
  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              data_request = 1'b0;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [W-1:0]      mem_rdata = '0;
  logic [DW-1:0]     training_data;
  logic [TYPE_W-1:0] training_data_type;
  logic              read_done, all_read, busy;

  always #5 clk = ~clk;

  training_sample_fetcher #(
    .M(M), .N(N), .W(W), .TYPE_W(TYPE_W), .MAX_ELEMENTS(MAX_ELEMENTS), .ADDR_W(ADDR_W)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .data_request(data_request),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .training_data(training_data), .training_data_type(training_data_type),
    .read_done(read_done), .all_read(all_read), .busy(busy)
  );

  // Memory: word at address a holds a+1, one-cycle read latency.
  always @(posedge clk) if (mem_rd_en) mem_rdata <= W'(mem_addr + 1);

  // scoreboard
  int n_checks = 0;
  int n_fail   = 0;
  logic [ADDR_W-1:0]      exp_q[$];
  logic [DW+TYPE_W-1:0]   exp_smp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [DW+TYPE_W-1:0] sample_of(input int base);
    logic [DW-1:0] d;
    logic [W-1:0]  lbl;
    for (int k = 0; k < PIX; k++) d[k*W +: W] = W'(base + k + 1);
    lbl = W'(base + PIX + 1);
    return {lbl[TYPE_W-1:0], d};
  endfunction

  // Timeline model: a fetch accepted at edge e0 reads on e0..e0+WPS-1, pulses
  // read_done at e0+WPS+1 and is back in IDLE (index advanced) at e0+WPS+2.
  int                edge_n = 0;
  int                m_e0 = 0, m_base = 0, m_idx = 0;
  bit                m_active = 0, m_all_read = 0, m_after_rst = 0, m_known = 0;
  bit                checking = 0;
  logic [DW-1:0]     m_data = '0;
  logic [TYPE_W-1:0] m_type = '0;

  always @(posedge clk) begin
    edge_n++;
    checking = 1;
    if (rst) begin
      m_active = 0; m_idx = 0; m_all_read = 0; m_after_rst = 1;
      m_known = 1; m_data = '0; m_type = '0;
    end else begin
      m_after_rst = 0;
      if (WRAP) m_all_read = 0;
      if (start) begin
        if (m_active) m_known = 0;
        m_active = 0; m_idx = 0; m_all_read = 0;
      end else if (m_active) begin
        if (edge_n - m_e0 == WPS + 1) begin
          {m_type, m_data} = sample_of(m_base);
          m_known = 1;
        end else if (edge_n - m_e0 == WPS + 2) begin
          m_active = 0;
          m_idx++;
          if (m_idx == MAX_ELEMENTS) begin
            m_all_read = 1;
            if (WRAP) m_idx = 0;
          end
        end
      end else if (data_request && (WRAP || !m_all_read)) begin
        m_active = 1; m_e0 = edge_n; m_base = m_idx * WPS;
      end
    end
  end

  // Compare process
  always @(negedge clk) begin : compare
    int off;
    bit e_rd, e_done;
    if (checking) begin
      off    = edge_n - m_e0;
      e_rd   = m_active && (off <= WPS - 1);
      e_done = m_active && (off == WPS + 1);
      check("mem_rd_en", mem_rd_en, e_rd);
      if (e_rd) check("mem_addr", mem_addr, ADDR_W'(m_base + off));
      check("read_done", read_done, e_done);
      check("busy", busy, m_active);
      check("all_read", all_read, m_all_read);
      if (m_after_rst) check("mem_addr_rst", mem_addr, 0);
      if (m_known && (!m_active || e_done)) begin
        check("training_data", training_data, m_data);
        check("training_data_type", training_data_type, m_type);
      end
      if (mem_rd_en === 1'b1) begin
        if (exp_q.size() == 0) check("unexpected_read", mem_rd_en, 0);
        else                   check("addr_literal", mem_addr, exp_q.pop_front());
      end
      if (read_done === 1'b1) begin
        if (exp_smp_q.size() == 0) check("unexpected_read_done", read_done, 0);
        else check("sample_literal", {training_data_type, training_data}, exp_smp_q.pop_front());
      end
    end
  end

  // driver tasks
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic request_pulse();
    data_request = 1'b1;
    @(negedge clk);
    data_request = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int budget = 60;
    while (busy !== 1'b0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    check(name, busy, 0);
  endtask

  task automatic expect_reads(input int base, input int nwords);
    for (int j = 0; j < nwords; j++) exp_q.push_back(ADDR_W'(base + j));
  endtask

  initial begin
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(1);
    check("reset_busy", busy, 0);
    check("reset_data", training_data, 0);

    // single request: addresses 0..4, pixels 1..4, label 5 & 3 = 1
    expect_reads(0, 5);
    exp_smp_q.push_back({2'd1, 32'h04030201});
    request_pulse();
    wait_idle("first_fetch_idle");
    check("s0_data", training_data, 64'h04030201);
    check("s0_type", training_data_type, 1);

    // request held high: one fetch at a time, samples at bases 5 and 10
    expect_reads(5, 5);
    exp_smp_q.push_back({2'd2, 32'h09080706});
    expect_reads(10, 5);
    exp_smp_q.push_back({2'd3, 32'h0E0D0C0B});
    data_request = 1'b1;
    tick(12);
    data_request = 1'b0;
    wait_idle("held_request_idle");
    check("s2_type", training_data_type, 3);

`ifdef SAMPLE_WRAP_EN
    check("all_read_pulse_over", all_read, 0);
    expect_reads(0, 5);
    exp_smp_q.push_back({2'd1, 32'h04030201});
    request_pulse();
    wait_idle("wrap_fetch_idle");
`else
    check("all_read_latched", all_read, 1);
    request_pulse();
    tick(10);
    check("no_fetch_after_all_read", busy, 0);
`endif

    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(1);
    check("start_clears_all_read", all_read, 0);

    // abort: start sampled at e0+4 -> reads 0..3 only, no read_done
    expect_reads(0, 4);
    data_request = 1'b1;
    tick(1);
    data_request = 1'b0;
    tick(3);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    check("abort_rd_en_low", mem_rd_en, 0);
    check("abort_busy", busy, 0);
    tick(8);

    expect_reads(0, 5);
    exp_smp_q.push_back({2'd1, 32'h04030201});
    request_pulse();
    wait_idle("after_abort_idle");

    // reset in the middle of fetching sample 1
    expect_reads(5, 2);
    data_request = 1'b1;
    tick(1);
    data_request = 1'b0;
    tick(1);
    rst = 1'b1;
    tick(1);
    check("rst_rd_en", mem_rd_en, 0);
    check("rst_data", training_data, 0);
    check("rst_type", training_data_type, 0);
    rst = 1'b0;
    tick(2);

    // start and request together: request dropped
    start = 1'b1;
    data_request = 1'b1;
    tick(1);
    start = 1'b0;
    data_request = 1'b0;
    tick(6);
    check("start_beats_request", busy, 0);

    expect_reads(0, 5);
    exp_smp_q.push_back({2'd1, 32'h04030201});
    request_pulse();
    wait_idle("final_fetch_idle");
    tick(2);

    check("addr_queue_drained", exp_q.size(), 0);
    check("sample_queue_drained", exp_smp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, time=%0t, limit=100000", $time);
    $fatal(1);
  end

endmodule
